// File: rtl/up_counter.sv
// -----------------------------------------------------------------------------
// up_counter
//   Enable-driven up counter with a programmable terminal count. A small FSM
//   (IDLE / COUNT / PAUSE / DONE) tracks whether counting is active, paused,
//   or has stopped at the terminal value. At terminal count the block either
//   wraps to 0 with a one-cycle done pulse (wrap_en=1) or parks in DONE with
//   done held high (wrap_en=0) until a reset.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rstn         in   asynchronous active-low reset
//   start        in   level-sensitive count enable
//   reset        in   synchronous active-high clear (beats everything but rstn)
//   limit        in   [WIDTH] terminal count, unsigned, sampled every cycle
//   wrap_en      in   1: wrap to 0 after limit, 0: stop at limit
//   counter_out  out  [WIDTH] registered count
//   done         out  registered terminal-count indication
//   running      out  registered, high exactly while in COUNT
//   VDD, VSS     io   power pins, no logic function
// -----------------------------------------------------------------------------
module up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             reset,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] counter_out,
  output logic             done,
  output logic             running,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_done;
  logic             r_running;

  // Terminal match compares against the live limit. A limit lowered below
  // the current count never matches until the count rolls over naturally.
  logic             w_at_limit;
  logic [WIDTH-1:0] w_cnt_inc;

  assign w_at_limit = (r_cnt == limit);
  assign w_cnt_inc  = r_cnt + 1'b1;   // WIDTH-bit, carry discarded

  // Power pins are carried through for netlist connectivity only.
  wire w_unused_pwr;
  assign w_unused_pwr = VDD ^ VSS;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_COUNT, ST_PAUSE: begin
          if (start && w_at_limit) begin
            if (wrap_en) begin
              // Wrap: back to 0, keep counting, single-cycle done pulse.
              r_state   <= ST_COUNT;
              r_cnt     <= '0;
              r_done    <= 1'b1;
              r_running <= 1'b1;
            end else begin
              // Stop: park at limit with done held.
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end
          end else if (start) begin
            r_state   <= ST_COUNT;
            r_cnt     <= w_cnt_inc;
            r_done    <= 1'b0;
            r_running <= 1'b1;
          end else begin
            // Enable dropped: COUNT pauses, IDLE/PAUSE stay put.
            if (r_state == ST_COUNT) r_state <= ST_PAUSE;
            r_done    <= 1'b0;
            r_running <= 1'b0;
          end
        end
        ST_DONE: begin
          // Sticky until reset/rstn; start is ignored here.
          r_done    <= 1'b1;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_done    <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign counter_out = r_cnt;
  assign done        = r_done;
  assign running     = r_running;

endmodule
